popcount_pipe: RTL and testbench
================================

Name: popcount_pipe

Overview:
- Registered population-count block: counts the '1' bits in an input word and returns the count with valid and status flags.
- Sits on a valid-qualified datapath as a drop-in, clocked replacement for the combinational ones-counter `count`.
- Two-stage pipeline:
  - Stage 1 forms nibble partial counts.
  - Stage 2 sums the partials and derives the flags.

Parameters:
- DATA_W, 8: input word width in bits; must be a multiple of 4 and at least 4.
- CNT_W, $clog2(DATA_W+1): count width; 4 for DATA_W=8.

Ports:
- clk        input   1        single clock; all state updates on its rising edge.
- rst_n      input   1        reset; asynchronous assert, active-low.
- in_valid   input   1        data_in is valid this cycle.
- data_in    input   DATA_W   word to count.
- out_valid  output  1        count_out and flags are valid this cycle.
- count_out  output  CNT_W    number of '1' bits in the word accepted two cycles earlier; range 0..DATA_W.
- all_zero   output  1        count_out == 0.
- all_ones   output  1        count_out == DATA_W.
- parity     output  1        XOR of all bits of the word (count_out[0]).

Behaviour:
- Reset:
  - rst_n low clears every register immediately, without waiting for clk.
  - During reset: out_valid=0, count_out=0, all_zero=0, all_ones=0, parity=0.
  - Both pipeline stages are cleared.
  - On deassertion, the first possible out_valid is 2 rising edges after the first sampled in_valid=1.
- Stage 1, on the edge where in_valid=1:
  - Register DATA_W/4 nibble counts, each 3 bits, range 0..4.
  - Register the stage-1 valid bit.
  - When in_valid=0, the stage-1 valid bit clears and the partial-count registers hold their values.
- Stage 2:
  - When the stage-1 valid bit is set, register the sum of the partials into count_out.
  - In the same cycle, register all_zero, all_ones and parity from that sum.
  - out_valid follows the stage-1 valid bit one cycle later.
- Latency and throughput:
  - Latency exactly 2 clock cycles from a sampled in_valid to out_valid.
  - Full throughput: one word per cycle; back-to-back words give back-to-back results in order.
  - No backpressure; no ready signal.
- Output hold:
  - When out_valid=0, count_out and the flags hold their last valid values; they do not return to 0.
  - Exception: reset clears them to 0.
- Arithmetic:
  - Unsigned adder tree sized so the maximum sum DATA_W never overflows CNT_W.
  - No saturation is needed.
- data_in is sampled only when in_valid=1; X on data_in while in_valid=0 must not propagate.
- Reset mid-operation:
  - In-flight words are discarded.
  - No out_valid pulse is generated for them after reset release.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst_n=0 and toggle clk, then deassert with in_valid=0 → out_valid=0, count_out=0, all flags 0. Assert rst_n low between clock edges → outputs clear before the next edge.
- Directed values, one per cycle with in_valid=1, DATA_W=8. Each result appears with out_valid=1 exactly 2 cycles after its input:

  | data_in  | count_out | all_zero | all_ones | parity |
  |----------|-----------|----------|----------|--------|
  | 00000000 | 0         | 1        | 0        | 0      |
  | 00000001 | 1         | 0        | 0        | 1      |
  | 11111111 | 8         | 0        | 1        | 0      |
  | 10101010 | 4         | 0        | 0        | 0      |
  | 11001100 | 4         | 0        | 0        | 0      |
  | 10000001 | 2         | 0        | 0        | 0      |
  | 00110110 | 4         | 0        | 0        | 0      |

- Bubbles: word 11111111, then in_valid=0 for 2 cycles, then 00000001 → out_valid pattern 1,0,0,1. count_out holds 8 through the bubbles, then shows 1.
- Reset mid-stream: send 11111111 and 10101010 back-to-back, pull rst_n low one cycle later, release → no out_valid for either word; outputs read 0.
- Exhaustive: all 256 values back-to-back → every count_out equals the reference popcount. out_valid stays high continuously after the 2-cycle fill.
- Parameter check, DATA_W=16 (CNT_W=5): 0xFFFF gives count_out=16 with all_ones=1, and 0x8001 gives count_out=2.

Source files
------------

// File: rtl/popcount_pipe_if.sv
// Valid-qualified request/result bundle for the pipelined ones-counter.
// The master drives words in; the slave (the counter) returns the count and flags.
interface popcount_pipe_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
);
    logic              in_valid;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic [CNT_W-1:0]  count_out;
    logic              all_zero;
    logic              all_ones;
    logic              parity;

    modport master (
        output in_valid,
        output data_in,
        input  out_valid,
        input  count_out,
        input  all_zero,
        input  all_ones,
        input  parity
    );

    modport slave (
        input  in_valid,
        input  data_in,
        output out_valid,
        output count_out,
        output all_zero,
        output all_ones,
        output parity
    );
endinterface

// File: rtl/popcount_pipe.sv
// Two-stage registered population count: nibble partial counts, then summed
// count with zero/ones/parity flags. DATA_W must be a multiple of 4, >= 4.
module popcount_pipe #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
    input logic            clk,
    input logic            rst_n,
    popcount_pipe_if.slave bus
);

    localparam int unsigned NIB_N = DATA_W / 4;
    localparam int unsigned NIB_W = 3;

    logic [NIB_N-1:0][NIB_W-1:0] nib_next;
    logic [NIB_N-1:0][NIB_W-1:0] nib_q;
    logic                        s1_valid;
    logic [CNT_W-1:0]            sum;

    logic                        out_valid;
    logic [CNT_W-1:0]            count_out;
    logic                        all_zero;
    logic                        all_ones;
    logic                        parity;

    // Per-nibble ones count, 0..4
    always_comb begin
        nib_next = '0;
        for (int i = 0; i < int'(NIB_N); i++) begin
            nib_next[i] = NIB_W'(bus.data_in[4*i])     + NIB_W'(bus.data_in[4*i+1])
                        + NIB_W'(bus.data_in[4*i+2])   + NIB_W'(bus.data_in[4*i+3]);
        end
    end

    // Stage 1: partials only load on a valid word so idle X never enters the pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            nib_q    <= '0;
        end else begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                nib_q <= nib_next;
            end
        end
    end

    // Adder tree over partials; CNT_W holds DATA_W so it cannot overflow
    always_comb begin
        sum = '0;
        for (int i = 0; i < int'(NIB_N); i++) begin
            sum = sum + CNT_W'(nib_q[i]);
        end
    end

    // Stage 2: results hold their last valid value while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            count_out <= '0;
            all_zero  <= 1'b0;
            all_ones  <= 1'b0;
            parity    <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                count_out <= sum;
                all_zero  <= (sum == '0);
                all_ones  <= (sum == CNT_W'(DATA_W));
                parity    <= sum[0];
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.count_out = count_out;
    assign bus.all_zero  = all_zero;
    assign bus.all_ones  = all_ones;
    assign bus.parity    = parity;

endmodule

// File: tb/tb_popcount_pipe.sv
// Bench for popcount_pipe: 8-bit and 16-bit instances driven in lockstep and
// compared every cycle against a queue-based reference of accepted words.
module tb_popcount_pipe;

    logic clk;
    logic rst_n;

    popcount_pipe_if #(.DATA_W(8))  if8  ();
    popcount_pipe_if #(.DATA_W(16)) if16 ();

    popcount_pipe #(.DATA_W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    popcount_pipe #(.DATA_W(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Reference: words sampled at each edge since reset; results are the
    // word sampled one edge before the most recent one.
    bit          qv[$];
    logic [7:0]  q8[$];
    logic [15:0] q16[$];
    int e8_cnt, e8_az, e8_ao, e8_par;
    int e16_cnt, e16_az, e16_ao, e16_par;
    int e_valid;

    task automatic model_reset();
        qv.delete(); q8.delete(); q16.delete();
        e_valid = 0;
        e8_cnt = 0;  e8_az = 0;  e8_ao = 0;  e8_par = 0;
        e16_cnt = 0; e16_az = 0; e16_ao = 0; e16_par = 0;
    endtask

    task automatic check_outputs(input string ph);
        check({ph, "_v8"},    int'(if8.out_valid),  e_valid);
        check({ph, "_cnt8"},  int'(if8.count_out),  e8_cnt);
        check({ph, "_az8"},   int'(if8.all_zero),   e8_az);
        check({ph, "_ao8"},   int'(if8.all_ones),   e8_ao);
        check({ph, "_par8"},  int'(if8.parity),     e8_par);
        check({ph, "_v16"},   int'(if16.out_valid), e_valid);
        check({ph, "_cnt16"}, int'(if16.count_out), e16_cnt);
        check({ph, "_az16"},  int'(if16.all_zero),  e16_az);
        check({ph, "_ao16"},  int'(if16.all_ones),  e16_ao);
        check({ph, "_par16"}, int'(if16.parity),    e16_par);
    endtask

    // One clock: drive at negedge, sample 1 time unit after posedge, compare
    task automatic cycle(input string ph, input bit v, input logic [7:0] d8, input logic [15:0] d16);
        int n;
        @(negedge clk);
        if8.in_valid  = v;
        if16.in_valid = v;
        if8.data_in   = v ? d8  : 8'hxx;
        if16.data_in  = v ? d16 : 16'hxxxx;
        @(posedge clk);
        #1;
        qv.push_back(v); q8.push_back(d8); q16.push_back(d16);
        n = qv.size();
        e_valid = 0;
        if (n >= 2 && qv[n-2]) begin
            e_valid = 1;
            e8_cnt  = $countones(q8[n-2]);
            e8_az   = int'(e8_cnt == 0);
            e8_ao   = int'(e8_cnt == 8);
            e8_par  = int'(^q8[n-2]);
            e16_cnt = $countones(q16[n-2]);
            e16_az  = int'(e16_cnt == 0);
            e16_ao  = int'(e16_cnt == 16);
            e16_par = int'(^q16[n-2]);
        end
        if (n > 3) begin
            void'(qv.pop_front()); void'(q8.pop_front()); void'(q16.pop_front());
        end
        check_outputs(ph);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge
    task automatic async_reset(input string ph);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        if8.in_valid  = 1'b0;
        if16.in_valid = 1'b0;
        #1;
        model_reset();
        check_outputs({ph, "_async"});
        repeat (2) begin
            @(posedge clk);
            #1;
            check_outputs({ph, "_held"});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] dir8 [7] = '{8'b00000000, 8'b00000001, 8'b11111111, 8'b10101010,
                             8'b11001100, 8'b10000001, 8'b00110110};

    initial begin
        rst_n = 1'b0;
        if8.in_valid = 1'b0;  if8.data_in = '0;
        if16.in_valid = 1'b0; if16.data_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) cycle("idle", 1'b0, 8'h00, 16'h0000);

        // Directed table, back-to-back, plus the 16-bit boundary words
        for (int i = 0; i < 7; i++) cycle("dir", 1'b1, dir8[i], 16'(i * 16'h1111));
        cycle("w16", 1'b1, 8'hFF, 16'hFFFF);
        cycle("w16", 1'b1, 8'h01, 16'h8001);
        cycle("w16", 1'b1, 8'h00, 16'h0000);
        repeat (2) cycle("drain", 1'b0, 8'h00, 16'h0000);

        // Bubbles: results hold through idle cycles
        cycle("bub", 1'b1, 8'hFF, 16'hFFFF);
        cycle("bub", 1'b0, 8'h00, 16'h0000);
        cycle("bub", 1'b0, 8'h00, 16'h0000);
        cycle("bub", 1'b1, 8'h01, 16'h0001);
        repeat (2) cycle("bub", 1'b0, 8'h00, 16'h0000);

        // Reset mid-stream: in-flight words must never emerge
        cycle("mid", 1'b1, 8'hFF, 16'hFFFF);
        cycle("mid", 1'b1, 8'hAA, 16'hAAAA);
        async_reset("mid");
        repeat (3) cycle("post", 1'b0, 8'h00, 16'h0000);

        // Exhaustive 8-bit sweep, continuous valid
        for (int i = 0; i < 256; i++) cycle("sweep", 1'b1, 8'(i), 16'($urandom));
        repeat (2) cycle("drain", 1'b0, 8'h00, 16'h0000);

        // Random traffic with random bubbles
        for (int i = 0; i < 300; i++)
            cycle("rand", 1'($urandom_range(0, 3) != 0), 8'($urandom), 16'($urandom));
        repeat (3) cycle("drain", 1'b0, 8'h00, 16'h0000);

        async_reset("end");
        cycle("fin", 1'b0, 8'h00, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
